// File: rtl/key_event.sv
// Key event encoder: turns debounced key levels into press/release/auto-repeat events
// on a ready/valid stream and tracks the most recently pressed (active) key.
module key_event_slot (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic clr_press,
  input  logic clr_rel,
  input  logic clr_rep,
  input  logic set_rep,
  output logic held,
  output logic pend_press,
  output logic pend_rel,
  output logic pend_rep,
  output logic drop
);
  logic rise, fall, keep_press, keep_rel;

  assign rise       = key & ~held;
  assign fall       = ~key & held;
  assign keep_press = pend_press & ~clr_press;
  assign keep_rel   = pend_rel & ~clr_rel;
  // An edge arriving while its pending bit survives this cycle is folded into it.
  assign drop       = (rise & keep_press) | (fall & keep_rel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held       <= 1'b0;
      pend_press <= 1'b0;
      pend_rel   <= 1'b0;
      pend_rep   <= 1'b0;
    end else begin
      held       <= key;
      pend_press <= keep_press | rise;
      pend_rel   <= keep_rel | fall;
      pend_rep   <= ((pend_rep & ~clr_rep) | set_rep) & key;
    end
  end
endmodule

module key_event #(
  parameter int NKEYS           = 8,
  parameter int CLK_FREQ_KHZ    = 100_000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NKEYS-1:0]         keys,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [$clog2(NKEYS)-1:0] evt_code,
  output logic [1:0]               evt_kind,
  output logic [NKEYS-1:0]         held,
  output logic                     active_valid,
  output logic [$clog2(NKEYS)-1:0] active_code,
  output logic                     evt_drop
);
  localparam int CW = $clog2(NKEYS);
  localparam logic [31:0] DELAY_CYC = 32'(CLK_FREQ_KHZ * REPEAT_DELAY_MS);
  localparam logic [31:0] RATE_CYC  = 32'(CLK_FREQ_KHZ * REPEAT_RATE_MS);

  typedef enum logic [1:0] {
    KIND_REL   = 2'b00,
    KIND_PRESS = 2'b01,
    KIND_REP   = 2'b10
  } kind_e;

  logic [NKEYS-1:0] pend_press, pend_rel, pend_rep, drop;
  logic [NKEYS-1:0] clr_press, clr_rel, clr_rep, set_rep;
  logic [NKEYS-1:0] rise, fall;
  logic             load, sel_found;
  logic [CW-1:0]    sel_idx;
  kind_e            sel_kind;
  logic             act_v_n, restart, fire, first_done;
  logic [CW-1:0]    act_c_n;
  logic [31:0]      cnt, target;

  function automatic logic [CW-1:0] lowest(input logic [NKEYS-1:0] v);
    lowest = '0;
    for (int i = NKEYS - 1; i >= 0; i--)
      if (v[i]) lowest = CW'(i);
  endfunction

  for (genvar g = 0; g < NKEYS; g++) begin : g_slot
    key_event_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .key       (keys[g]),
      .clr_press (clr_press[g]),
      .clr_rel   (clr_rel[g]),
      .clr_rep   (clr_rep[g]),
      .set_rep   (set_rep[g]),
      .held      (held[g]),
      .pend_press(pend_press[g]),
      .pend_rel  (pend_rel[g]),
      .pend_rep  (pend_rep[g]),
      .drop      (drop[g])
    );
  end

  assign rise = keys & ~held;
  assign fall = ~keys & held;
  assign load = ~evt_valid | evt_ready;

  // Descending scan so the lowest pending index is the one left selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_kind  = KIND_REL;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend_press[i] | pend_rel[i] | pend_rep[i]) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
        sel_kind  = pend_press[i] ? KIND_PRESS : (pend_rel[i] ? KIND_REL : KIND_REP);
      end
    end
  end

  always_comb begin
    clr_press = '0;
    clr_rel   = '0;
    clr_rep   = '0;
    if (load && sel_found) begin
      case (sel_kind)
        KIND_PRESS: clr_press[sel_idx] = 1'b1;
        KIND_REL:   clr_rel[sel_idx]   = 1'b1;
        default:    clr_rep[sel_idx]   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_kind  <= 2'b00;
      evt_drop  <= 1'b0;
    end else begin
      evt_drop <= evt_drop | (|drop);
      if (load) begin
        evt_valid <= sel_found;
        if (sel_found) begin
          evt_code <= sel_idx;
          evt_kind <= sel_kind;
        end
      end
    end
  end

  // Newest rise takes over; losing the active key falls back to the lowest one still down.
  always_comb begin
    act_v_n = active_valid;
    act_c_n = active_code;
    if (|rise) begin
      act_v_n = 1'b1;
      act_c_n = lowest(rise);
    end else if (active_valid && fall[active_code]) begin
      act_v_n = |keys;
      act_c_n = lowest(keys);
    end
  end

  assign restart = act_v_n & (~active_valid | (act_c_n != active_code));
  assign target  = first_done ? RATE_CYC : DELAY_CYC;
  assign fire    = active_valid & act_v_n & ~restart & ((cnt + 32'd1) == target);

  always_comb begin
    set_rep              = '0;
    set_rep[active_code] = fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_valid <= 1'b0;
      active_code  <= '0;
      cnt          <= '0;
      first_done   <= 1'b0;
    end else begin
      active_valid <= act_v_n;
      active_code  <= act_c_n;
      if (!act_v_n || restart) begin
        cnt        <= '0;
        first_done <= 1'b0;
      end else if (fire) begin
        cnt        <= '0;
        first_done <= 1'b1;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: expected events are queued with the cycle they should
// hand off on; a negedge monitor pops and compares every accepted event.
module tb_key_event;
  localparam int NK = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys = '0;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [CW-1:0] evt_code;
  logic [1:0]    evt_kind;
  logic [NK-1:0] held;
  logic          active_valid;
  logic [CW-1:0] active_code;
  logic          evt_drop;

  key_event #(
    .NKEYS(NK), .CLK_FREQ_KHZ(1), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(4)
  ) dut (
    .clk(clk), .rst(rst), .keys(keys), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_kind(evt_kind),
    .held(held), .active_valid(active_valid), .active_code(active_code),
    .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int code; int kind; int at; } exp_t;
  exp_t sb[$];

  task automatic push(input int code, input int kind, input int at);
    exp_t e;
    e.code = code; e.kind = kind; e.at = at;
    sb.push_back(e);
  endtask

  // Advance to just after the clock edge that makes cyc == c.
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic          pv = 1'b0;
  logic [CW-1:0] pc;
  logic [1:0]    pk;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        chk("stall_valid", evt_valid, 1);
        chk("stall_code", evt_code, pc);
        chk("stall_kind", evt_kind, pk);
      end
      if (evt_valid && evt_ready) begin
        chk("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("evt_code", evt_code, e.code);
          chk("evt_kind", evt_kind, e.kind);
          if (e.at >= 0) chk("evt_cycle", cyc, e.at);
        end
      end
      pv = evt_valid && !evt_ready;
      pc = evt_code;
      pk = evt_kind;
    end
  end

  int t;

  initial begin
    #2;
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_kind", evt_kind, 0);
    chk("rst_held", held, 0);
    chk("rst_active_valid", active_valid, 0);
    chk("rst_active_code", active_code, 0);
    chk("rst_drop", evt_drop, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    go(cyc + 2);

    // single press with ready high
    evt_ready = 1'b1;
    t = cyc;
    keys = 8'h04;
    push(2, 1, t + 2);
    go(t + 1);
    chk("held_copy", held, 8'h04);
    go(t + 2);
    chk("active_code_2", active_code, 2);
    chk("active_valid_2", active_valid, 1);
    go(t + 3);
    t = cyc;
    keys = 8'h00;
    push(2, 0, t + 2);
    go(t + 4);
    chk("active_cleared", active_valid, 0);

    // two simultaneous presses against a stalled consumer
    evt_ready = 1'b0;
    t = cyc;
    keys = 8'h81;
    push(0, 1, t + 7);
    push(7, 1, t + 8);
    go(t + 2);
    chk("simul_active_lowest", active_code, 0);
    go(t + 4);
    chk("stalled_valid", evt_valid, 1);
    go(t + 7);
    evt_ready = 1'b1;
    go(t + 9);
    t = cyc;
    keys = 8'h00;
    push(0, 0, t + 2);
    push(7, 0, t + 3);
    go(t + 6);

    // auto-repeat on a held key
    t = cyc;
    keys = 8'h08;
    push(3, 1, t + 2);
    push(3, 2, t + 12);
    push(3, 2, t + 16);
    push(3, 2, t + 20);
    go(t + 21);
    keys = 8'h00;
    push(3, 0, t + 23);
    go(t + 40);

    // active key handoff, counter restart, simultaneous press/release
    t = cyc;
    keys = 8'h02;
    push(1, 1, t + 2);
    go(t + 1);
    chk("active_1", active_code, 1);
    go(t + 5);
    keys = 8'h22;
    push(5, 1, t + 7);
    go(t + 6);
    chk("active_5", active_code, 5);
    go(t + 8);
    keys = 8'h02;
    push(5, 0, t + 10);
    go(t + 9);
    chk("active_back_1", active_code, 1);
    push(1, 2, t + 20);
    go(t + 21);
    keys = 8'h04;
    push(1, 0, t + 23);
    push(2, 1, t + 24);
    go(t + 23);
    chk("active_2_swap", active_code, 2);
    go(t + 25);
    keys = 8'h00;
    push(2, 0, t + 27);
    go(t + 32);
    chk("sb_drained", sb.size(), 0);

    // coalesced edge with a blocked output, then reset mid-handshake
    evt_ready = 1'b0;
    t = cyc;
    keys = 8'h01;
    go(t + 3);
    keys = 8'h11;
    go(t + 4);
    keys = 8'h01;
    go(t + 5);
    chk("drop_before", evt_drop, 0);
    keys = 8'h11;
    go(t + 6);
    chk("drop_set", evt_drop, 1);
    chk("blocked_code", evt_code, 0);
    chk("blocked_kind", evt_kind, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", evt_valid, 0);
    chk("arst_code", evt_code, 0);
    chk("arst_kind", evt_kind, 0);
    chk("arst_held", held, 0);
    chk("arst_active_valid", active_valid, 0);
    chk("arst_active_code", active_code, 0);
    chk("arst_drop", evt_drop, 0);
    sb.delete();
    evt_ready = 1'b1;
    go(cyc + 2);
    chk("held_in_rst", held, 0);

    // keys already down when reset lifts
    t = cyc;
    rst = 1'b0;
    push(0, 1, t + 2);
    push(4, 1, t + 3);
    go(t + 5);
    t = cyc;
    keys = 8'h00;
    push(0, 0, t + 2);
    push(4, 0, t + 3);
    go(t + 8);
    chk("sb_final_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter NKEYS, default 8: number of key inputs (2..16).
REQ-002 Parameter CLK_FREQ_KHZ, default 100_000: clock frequency in kHz.
REQ-003 Parameter REPEAT_DELAY_MS, default 500: hold time before the first auto-repeat.
REQ-004 Parameter REPEAT_RATE_MS, default 100: interval between subsequent auto-repeats.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port keys, input, NKEYS: debounced key levels, 1 = pressed, synchronous to clk.
REQ-008 Port evt_ready, input, 1: consumer accepts the event this cycle.
REQ-009 Port evt_valid, output, 1: event on evt_code/evt_kind is valid.
REQ-010 Port evt_code, output, clog2(NKEYS): key index of the event.
REQ-011 Port evt_kind, output, 2: event type; 00 release, 01 press, 10 repeat; 11 is never driven.
REQ-012 Port held, output, NKEYS: registered copy of keys.
REQ-013 Port active_valid, output, 1: at least one key is held.
REQ-014 Port active_code, output, clog2(NKEYS): current active (last-pressed) key.
REQ-015 Port evt_drop, output, 1: sticky flag, set when an edge is coalesced.

Function
REQ-016 held SHALL equal keys delayed by one clock.
REQ-017 Rising edge (keys[i]=1, held[i]=0) SHALL set pend_press[i]; falling edge SHALL set pend_rel[i].
REQ-018 An edge whose pending bit is already set SHALL be coalesced (no extra event) and SHALL set evt_drop.
REQ-019 Output register SHALL load when evt_valid=0 or (evt_valid=1 and evt_ready=1), same-cycle reload allowed: one event per cycle maximum.
REQ-020 Arbitration: lowest key index with any pending bit wins; within a key, press before release before repeat.
REQ-021 Loading an event SHALL clear exactly the pending bit it represents.
REQ-022 While evt_valid=1 and evt_ready=0, evt_code and evt_kind SHALL hold stable.
REQ-023 Latency: input edge sampled at clock edge k SHALL produce evt_valid=1 after clock edge k+1 when the output register is free.
REQ-024 Active key: a rising edge SHALL make that key active; simultaneous rises select the lowest index.
REQ-025 Release of the active key SHALL make the lowest-index still-held key active, or clear active_valid if none held.
REQ-026 Release of a non-active key SHALL leave active_code unchanged.
REQ-027 Repeat counter (32-bit) SHALL restart at 0 whenever active_code changes or active_valid rises.
REQ-028 Counter SHALL set pend_rep[active] upon reaching CLK_FREQ_KHZ*REPEAT_DELAY_MS cycles, then every CLK_FREQ_KHZ*REPEAT_RATE_MS cycles.
REQ-029 Counter SHALL stop and clear while active_valid=0; pending repeats of released keys SHALL be cleared.
REQ-030 Simultaneous press of key i and release of key j in one cycle SHALL set both pending bits.

Reset
REQ-031 rst=1 SHALL asynchronously clear held, all pending bits, evt_valid, evt_code, evt_kind, active_valid, active_code, evt_drop and the repeat counter.
REQ-032 Keys high when rst deasserts SHALL generate press events (held reset value is 0).
REQ-033 Reset mid-handshake SHALL discard the current event without consumer acknowledge.

Verification (CLK_FREQ_KHZ=1, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=4, NKEYS=8)
REQ-034 keys 0x00->0x04, evt_ready=1 -> evt_valid=1 one cycle, code 2, kind 01, two edges after change; active_code=2.
REQ-035 keys 0x00->0x81 with evt_ready=0 for 5 cycles, then 1 -> press code 0 held stable 5 cycles, then press code 7 next cycle.
REQ-036 hold key 3 for 20 cycles, evt_ready=1 -> repeat (kind 10, code 3) 10 cycles after active, then at +14, +18; release -> kind 00 code 3, no further repeats.
REQ-037 press 1, press 5, release 5 -> active_code 1,5,1; repeat counter restarts at each change.
REQ-038 evt_ready=0, key 4 pulses 1,0,1 -> press and release pending, second rise coalesced, evt_drop=1; then rst=1 -> all outputs 0 immediately.
